// File: rtl/pitch_sequencer.sv
// Pitching-game controller: debounces the three buttons, owns the pitch-type
// selection and sequences windup, ball flight, swing judgement and result.
module pitch_sequencer #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned WINDUP_TICKS = 3,
  parameter int unsigned FAST_TICKS   = 2,
  parameter int unsigned SLOW_TICKS   = 5,
  parameter int unsigned LANE_LEN     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_mode,
  input  logic                btn_pitch,
  input  logic                btn_swing,
  output logic [1:0]          mode,
  output logic [LANE_LEN-1:0] ball_pos,
  output logic                busy,
  output logic                result_valid,
  output logic [1:0]          result
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned TW = $clog2(WINDUP_TICKS + FAST_TICKS + SLOW_TICKS + 1);
  localparam int unsigned IW = $clog2(LANE_LEN);
  localparam int unsigned LW = LANE_LEN;

  localparam logic [1:0] M_FAST   = 2'd0;
  localparam logic [1:0] M_CHANGE = 2'd1;
  localparam logic [1:0] M_SLIDER = 2'd2;

  localparam logic [1:0] R_HIT  = 2'd1;
  localparam logic [1:0] R_MISS = 2'd2;
  localparam logic [1:0] R_LOOK = 2'd3;

  typedef enum logic [1:0] {IDLE, WINDUP, FLIGHT, RESULT} state_t;

  // Bit 0 mode, bit 1 pitch, bit 2 swing.
  logic [2:0]    raw;
  logic [2:0]    sync1, sync2, press;
  logic [DW-1:0] deb_cnt [3];

  assign raw = {btn_swing, btn_pitch, btn_mode};

  // Two-flop synchronizer plus saturating debounce counter per button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= sync2[i] && (deb_cnt[i] == DW'(DEB_CYCLES - 1));
        if (!sync2[i])
          deb_cnt[i] <= '0;
        else if (deb_cnt[i] != DW'(DEB_CYCLES))
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
      end
    end
  end

  state_t        state, state_n;
  logic [1:0]    pitch_mode, pitch_mode_n, mode_n, result_n;
  logic [LW-1:0] ball_n;
  logic [IW-1:0] idx, idx_n;
  logic [TW-1:0] tick, tick_n, interval_c;
  logic          valid_n;

  // Slider breaks from fast to slow once the ball reaches the second half.
  always_comb begin
    case (pitch_mode)
      M_CHANGE: interval_c = TW'(SLOW_TICKS);
      M_SLIDER: interval_c = (idx < IW'(LANE_LEN / 2)) ? TW'(FAST_TICKS) : TW'(SLOW_TICKS);
      default:  interval_c = TW'(FAST_TICKS);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mode         <= M_FAST;
      pitch_mode   <= M_FAST;
      ball_pos     <= '0;
      idx          <= '0;
      tick         <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= 2'd0;
    end else begin
      state        <= state_n;
      mode         <= mode_n;
      pitch_mode   <= pitch_mode_n;
      ball_pos     <= ball_n;
      idx          <= idx_n;
      tick         <= tick_n;
      busy         <= (state_n != IDLE);
      result_valid <= valid_n;
      result       <= result_n;
    end
  end

  always_comb begin
    state_n      = state;
    mode_n       = mode;
    pitch_mode_n = pitch_mode;
    ball_n       = ball_pos;
    idx_n        = idx;
    tick_n       = tick;
    result_n     = result;
    valid_n      = 1'b0;
    case (state)
      IDLE: begin
        // A pitch press wins over a coincident mode press.
        if (press[1]) begin
          state_n      = WINDUP;
          pitch_mode_n = mode;
          tick_n       = '0;
          ball_n       = '0;
        end else if (press[0]) begin
          case (mode)
            M_FAST:   mode_n = M_CHANGE;
            M_CHANGE: mode_n = M_SLIDER;
            default:  mode_n = M_FAST;
          endcase
        end
      end
      WINDUP: begin
        if (tick == TW'(WINDUP_TICKS - 1)) begin
          state_n = FLIGHT;
          ball_n  = LW'(1);
          idx_n   = '0;
          tick_n  = '0;
        end else begin
          tick_n = tick + TW'(1);
        end
      end
      FLIGHT: begin
        // A swing is judged at the pre-move position even if the step expires.
        if (press[2]) begin
          state_n  = RESULT;
          ball_n   = '0;
          valid_n  = 1'b1;
          result_n = (idx == IW'(LANE_LEN - 1)) ? R_HIT : R_MISS;
        end else if (tick == interval_c - TW'(1)) begin
          if (idx == IW'(LANE_LEN - 1)) begin
            state_n  = RESULT;
            ball_n   = '0;
            valid_n  = 1'b1;
            result_n = R_LOOK;
          end else begin
            ball_n = ball_pos << 1;
            idx_n  = idx + IW'(1);
            tick_n = '0;
          end
        end else begin
          tick_n = tick + TW'(1);
        end
      end
      RESULT: begin
        state_n = IDLE;
        ball_n  = '0;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
